// File: rtl/ipsxe_floating_point_grs_gen_v1_0.sv
// Two-stage elastic normalize + guard/sticky + RNE increment generator feeding the APM rounding adder.
// Optional o_inexact output is enabled by defining IPSXE_FLOATING_POINT_GRS_INEXACT_EN.
module ipsxe_floating_point_grs_gen_v1_0 #(
  parameter int MAN_WIDTH = 52,
  parameter int IN_WIDTH  = 2*(MAN_WIDTH+1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [IN_WIDTH-1:0]   i_prod,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [MAN_WIDTH+1:0]  o_z_1,
  output logic                  o_norm
`ifdef IPSXE_FLOATING_POINT_GRS_INEXACT_EN
  ,
  output logic                  o_inexact
`endif
);

  localparam int KW = MAN_WIDTH + 1;
  // Bits below G when normalized; the unnormalized case has one fewer.
  localparam int SW = IN_WIDTH - MAN_WIDTH - 2;
  localparam int NG = (SW < 4) ? SW : 4;
  localparam int GS = (SW + NG - 1) / NG;
  localparam int PW = NG * GS;

  logic          v1_q, v2_q;
  logic          load1, load2, take_in, move;
  logic          norm_s, g_s;
  logic [KW-1:0] kept_s;
  logic [SW-1:0] low_s;
  logic [PW-1:0] low_pad;
  logic [NG-1:0] stk_s;

  logic          norm1_q, g1_q;
  logic [KW-1:0] kept1_q;
  logic [NG-1:0] stk1_q;

  logic          s2, inc;
  logic [KW:0]   z_d;
  logic [KW:0]   z_q;
  logic          norm_q;

  assign load2   = ~v2_q | i_ready;
  assign load1   = ~v1_q | load2;
  assign o_ready = load1;
  assign take_in = i_valid & load1;
  assign move    = v1_q & load2;

  always_comb begin
    norm_s = i_prod[IN_WIDTH-1];
    if (norm_s) begin
      kept_s = i_prod[IN_WIDTH-1 -: KW];
      g_s    = i_prod[SW];
      low_s  = i_prod[SW-1:0];
    end else begin
      kept_s = i_prod[IN_WIDTH-2 -: KW];
      g_s    = i_prod[SW-1];
      // Shifting drops bit SW-1 (now G) and zero-fills, leaving only the sticky bits.
      low_s  = i_prod[SW-1:0] << 1;
    end
    low_pad         = '0;
    low_pad[SW-1:0] = low_s;
  end

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_stk
      assign stk_s[gi] = |low_pad[gi*GS +: GS];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1_q    <= 1'b0;
      norm1_q <= 1'b0;
      g1_q    <= 1'b0;
      kept1_q <= '0;
      stk1_q  <= '0;
    end else begin
      if (load1) v1_q <= i_valid;
      if (take_in) begin
        norm1_q <= norm_s;
        g1_q    <= g_s;
        kept1_q <= kept_s;
        stk1_q  <= stk_s;
      end
    end
  end

  always_comb begin
    s2  = |stk1_q;
    inc = g1_q & (s2 | kept1_q[0]);
    z_d = {kept1_q, inc};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v2_q   <= 1'b0;
      z_q    <= '0;
      norm_q <= 1'b0;
    end else begin
      if (load2) v2_q <= v1_q;
      if (move) begin
        z_q    <= z_d;
        norm_q <= norm1_q;
      end
    end
  end

`ifdef IPSXE_FLOATING_POINT_GRS_INEXACT_EN
  logic inex_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) inex_q <= 1'b0;
    else if (move) inex_q <= g1_q | s2;
  end
  assign o_inexact = inex_q;
`endif

  assign o_valid = v2_q;
  assign o_z_1   = z_q;
  assign o_norm  = norm_q;

endmodule

// File: tb/tb_ipsxe_floating_point_grs_gen_v1_0.sv
// Directed + streaming bench for the GRS generator at MAN_WIDTH=4, IN_WIDTH=10.
module tb_ipsxe_floating_point_grs_gen_v1_0;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [9:0] i_prod;
  logic       o_valid;
  logic       i_ready;
  logic [5:0] o_z_1;
  logic       o_norm;
`ifdef IPSXE_FLOATING_POINT_GRS_INEXACT_EN
  logic       o_inexact;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ipsxe_floating_point_grs_gen_v1_0 #(.MAN_WIDTH(4), .IN_WIDTH(10)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_prod  (i_prod),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_z_1   (o_z_1),
    .o_norm  (o_norm)
`ifdef IPSXE_FLOATING_POINT_GRS_INEXACT_EN
    ,
    .o_inexact(o_inexact)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  // Returns {norm, inexact, z[5:0]} computed straight from the rounding definition.
  function automatic logic [7:0] model(input logic [9:0] p);
    logic [4:0] kept;
    logic g, s, inc;
    if (p[9]) begin
      kept = p[9:5]; g = p[4]; s = |p[3:0];
    end else begin
      kept = p[8:4]; g = p[3]; s = |p[2:0];
    end
    inc = g & (s | kept[0]);
    return {p[9], g | s, kept, inc};
  endfunction

  task automatic check_inex(input string tag, input logic exp);
`ifdef IPSXE_FLOATING_POINT_GRS_INEXACT_EN
    check(tag, {31'd0, o_inexact}, {31'd0, exp});
`endif
  endtask

  task automatic send(input string tag, input logic [9:0] p, input logic [5:0] ez,
                      input logic en, input logic ex);
    @(negedge clk);
    i_valid = 1'b1; i_prod = p;
    check({tag, "_rdy"}, {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    check({tag, "_vld_early"}, {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, {31'd0, o_valid}, 32'd1);
    check({tag, "_z"}, {26'd0, o_z_1}, {26'd0, ez});
    check({tag, "_norm"}, {31'd0, o_norm}, {31'd0, en});
    check_inex({tag, "_inex"}, ex);
    @(negedge clk);
    check({tag, "_drain"}, {31'd0, o_valid}, 32'd0);
  endtask

  logic [9:0] pa, pb, pc;
  logic [9:0] sq [16];
  logic [7:0] m;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_prod = '0; i_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_vld",  {31'd0, o_valid}, 32'd0);
    check("rst_z",    {26'd0, o_z_1}, 32'd0);
    check("rst_norm", {31'd0, o_norm}, 32'd0);
    check("rst_rdy",  {31'd0, o_ready}, 32'd1);
    check_inex("rst_inex", 1'b0);
    rst = 1'b0; i_ready = 1'b1;

    send("tie_even", 10'b1011010000, 6'b101100, 1'b1, 1'b1);
    send("tie_odd",  10'b1011110000, 6'b101111, 1'b1, 1'b1);
    send("shifted",  10'b0101101100, 6'b101101, 1'b0, 1'b1);
    send("exact",    10'b1000000000, 6'b100000, 1'b1, 1'b0);
    send("all_ones", 10'b1111111111, 6'b111111, 1'b1, 1'b1);
    send("zero",     10'b0000000000, 6'b000000, 1'b0, 1'b0);
    send("sh_round", 10'b0111111000, 6'b111111, 1'b0, 1'b1);

    // Backpressure: three offers with downstream stalled.
    pa = 10'b1011010000; pb = 10'b0101101100; pc = 10'b1100110011;
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1; i_prod = pa;
    check("bp_rdy_a", {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    i_prod = pb;
    check("bp_rdy_b", {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    i_prod = pc;
    check("bp_rdy_full", {31'd0, o_ready}, 32'd0);
    m = model(pa);
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_vld", {31'd0, o_valid}, 32'd1);
      check("bp_hold_z", {26'd0, o_z_1}, {26'd0, m[5:0]});
      check("bp_hold_rdy", {31'd0, o_ready}, 32'd0);
      @(negedge clk);
    end
    i_ready = 1'b1;
    #1 check("bp_rdy_comb", {31'd0, o_ready}, 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    m = model(pb);
    check("bp_out_b_vld", {31'd0, o_valid}, 32'd1);
    check("bp_out_b_z", {26'd0, o_z_1}, {26'd0, m[5:0]});
    @(negedge clk);
    m = model(pc);
    check("bp_out_c_vld", {31'd0, o_valid}, 32'd1);
    check("bp_out_c_z", {26'd0, o_z_1}, {26'd0, m[5:0]});
    check("bp_out_c_norm", {31'd0, o_norm}, {31'd0, m[7]});
    @(negedge clk);
    check("bp_empty", {31'd0, o_valid}, 32'd0);

    // Streaming: word t is driven at iteration t and must show at iteration t+2.
    for (int t = 0; t < 16; t++) sq[t] = 10'($urandom_range(0, 1023));
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (t >= 2 && t < 18) begin
        m = model(sq[t-2]);
        check($sformatf("st%0d_vld", t-2), {31'd0, o_valid}, 32'd1);
        check($sformatf("st%0d_z", t-2), {26'd0, o_z_1}, {26'd0, m[5:0]});
        check($sformatf("st%0d_norm", t-2), {31'd0, o_norm}, {31'd0, m[7]});
        check_inex($sformatf("st%0d_inex", t-2), m[6]);
      end else begin
        check($sformatf("st_idle%0d", t), {31'd0, o_valid}, 32'd0);
      end
      if (t < 16) begin
        check($sformatf("st%0d_rdy", t), {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_prod = sq[t];
      end else begin
        i_valid = 1'b0;
      end
    end

    // Reset with two words in flight.
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1; i_prod = 10'b1111000011;
    @(negedge clk);
    i_prod = 10'b0110011001;
    @(negedge clk);
    i_valid = 1'b0;
    check("mid_full_vld", {31'd0, o_valid}, 32'd1);
    check("mid_full_rdy", {31'd0, o_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_vld",  {31'd0, o_valid}, 32'd0);
    check("mid_rst_z",    {26'd0, o_z_1}, 32'd0);
    check("mid_rst_norm", {31'd0, o_norm}, 32'd0);
    check("mid_rst_rdy",  {31'd0, o_ready}, 32'd1);
    check_inex("mid_rst_inex", 1'b0);
    @(negedge clk);
    rst = 1'b0; i_ready = 1'b1;
    check("post_rst_rdy", {31'd0, o_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_stale%0d", k), {31'd0, o_valid}, 32'd0);
    end
    send("post_rst", 10'b1011110000, 6'b101111, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
